// File: rtl/mc_control_if.sv
// Bus bundle for mc_control: instruction handshake, datapath control and memory handshake.
// The slave modport is the controller's view; master is the instruction source / datapath side.
interface mc_control_if #(
  parameter int CNT_W = 16
);
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       wa;
  logic [15:0]      imm;
  logic             alu_en;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic             reg_we;
  logic             wb_sel;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output inst_valid, inst, mem_ack,
    input  inst_ready, rs, rt, wa, imm, alu_en, alu_op, alu_src,
           mem_req, mem_we, reg_we, wb_sel, illegal, retired
  );

  modport slave (
    input  inst_valid, inst, mem_ack,
    output inst_ready, rs, rt, wa, imm, alu_en, alu_op, alu_src,
           mem_req, mem_we, reg_we, wb_sel, illegal, retired
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: ADD/SUB/SLT/LW/SW through DECODE/EXEC/MEM/WB phases.
// Optional MC_ILLEGAL_TRAP_EN: unsupported instructions halt until reset instead of retiring as NOPs.
//
// state  | meaning
// IDLE   | inst_ready high, waiting for an instruction
// DECODE | classify the latched instruction
// EXEC   | alu_en strobe, operand select and ALU op driven
// MEM    | mem_req held until mem_ack (LW/SW only)
// WB     | reg_we strobe for one cycle, then retire
// HALT   | unsupported instruction trapped, only rst leaves (trap build only)
module mc_control #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  mc_control_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef MC_ILLEGAL_TRAP_EN
    , ST_HALT
`endif
  } state_t;

  typedef enum logic [2:0] {
    K_ADD,
    K_SUB,
    K_SLT,
    K_LW,
    K_SW,
    K_BAD
  } kind_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_SLT    = 6'b101010;

  state_t           state_q, state_d;
  kind_t            kind;
  logic [5:0]       opc_q, funct_q;
  logic [4:0]       rs_q, rt_q, wa_q;
  logic [15:0]      imm_q;
  logic             alu_en_q, alu_en_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_src_q, alu_src_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             reg_we_q, reg_we_d;
  logic             wb_sel_q, wb_sel_d;
  logic [CNT_W-1:0] retired_q;
  logic             accept;
  logic             retire;
  logic             is_mem_op;

  assign bus.inst_ready = (state_q == ST_IDLE) & ~rst;
  assign accept         = bus.inst_valid & bus.inst_ready;

  // Classification is purely a function of the latched opcode/funct, so it is stable for the whole instruction.
  always_comb begin
    kind = K_BAD;
    case (opc_q)
      OPC_RTYPE: begin
        case (funct_q)
          FN_ADD:  kind = K_ADD;
          FN_SUB:  kind = K_SUB;
          FN_SLT:  kind = K_SLT;
          default: kind = K_BAD;
        endcase
      end
      OPC_LW:  kind = K_LW;
      OPC_SW:  kind = K_SW;
      default: kind = K_BAD;
    endcase
  end

  assign is_mem_op = (kind == K_LW) | (kind == K_SW);

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (kind == K_BAD) begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_IDLE;
          retire  = 1'b1;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = is_mem_op ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          if (kind == K_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
            retire  = 1'b1;
          end
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        retire  = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe lines up with its state.
  always_comb begin
    alu_en_d  = (state_d == ST_EXEC);
    alu_op_d  = 2'b00;
    alu_src_d = 1'b0;
    mem_req_d = (state_d == ST_MEM);
    mem_we_d  = 1'b0;
    reg_we_d  = (state_d == ST_WB);
    wb_sel_d  = 1'b0;
    if (alu_en_d) begin
      alu_src_d = is_mem_op;
      case (kind)
        K_SUB:   alu_op_d = 2'b01;
        K_SLT:   alu_op_d = 2'b10;
        default: alu_op_d = 2'b00;
      endcase
    end
    if (mem_req_d) mem_we_d = (kind == K_SW);
    if (reg_we_d)  wb_sel_d = (kind == K_LW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      funct_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wa_q      <= '0;
      imm_q     <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= 2'b00;
      alu_src_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      reg_we_q  <= reg_we_d;
      wb_sel_q  <= wb_sel_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (accept) begin
        opc_q   <= bus.inst[31:26];
        funct_q <= bus.inst[5:0];
        rs_q    <= bus.inst[25:21];
        rt_q    <= bus.inst[20:16];
        imm_q   <= bus.inst[15:0];
        wa_q    <= (bus.inst[31:26] == OPC_RTYPE) ? bus.inst[15:11] : bus.inst[20:16];
      end
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= (state_d == ST_HALT);
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.rs      = rs_q;
  assign bus.rt      = rt_q;
  assign bus.wa      = wa_q;
  assign bus.imm     = imm_q;
  assign bus.alu_en  = alu_en_q;
  assign bus.alu_op  = alu_op_q;
  assign bus.alu_src = alu_src_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.reg_we  = reg_we_q;
  assign bus.wb_sel  = wb_sel_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a reference model predicts every strobe cycle and counter change,
// a monitor pops and compares them as the DUT produces them.
module tb_mc_control;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  mc_control_if #(.CNT_W(CNT_W)) bus ();
  mc_control #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 1 = strobe cycle, 2 = retired counter change
    int          cyc;
    logic [63:0] v;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  passed = 0;
  int  model_cnt = 0;
  int  exp_ready = 0;

  function automatic logic [63:0] pk(logic [2:0] stb, logic [1:0] op, logic src, logic we,
                                     logic sel, logic [4:0] rs, logic [4:0] rt, logic [4:0] wa,
                                     logic [15:0] imm);
    return {25'b0, stb, op, src, we, sel, rs, rt, wa, imm};
  endfunction

  // 0 add, 1 sub, 2 slt, 3 lw, 4 sw, 5 unsupported
  function automatic int classify(logic [31:0] w);
    logic [5:0] o, f;
    o = w[31:26];
    f = w[5:0];
    if (o == 6'h00 && f == 6'h20) return 0;
    if (o == 6'h00 && f == 6'h22) return 1;
    if (o == 6'h00 && f == 6'h2A) return 2;
    if (o == 6'h23) return 3;
    if (o == 6'h2B) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] rand_inst(int k);
    logic [5:0]  badf [4];
    logic [31:0] r;
    r = $urandom;
    badf[0] = 6'h21; badf[1] = 6'h00; badf[2] = 6'h2B; badf[3] = 6'h08;
    case (k)
      0:       return {6'h00, r[25:6], 6'h20};
      1:       return {6'h00, r[25:6], 6'h22};
      2:       return {6'h00, r[25:6], 6'h2A};
      3:       return {6'h23, r[25:0]};
      4:       return {6'h2B, r[25:0]};
      default: begin
        case (r[31:30])
          2'd0:    return {6'h3F, r[25:0]};
          2'd1:    return {6'h00, r[25:6], badf[r[29:28]]};
          default: return {6'h04, r[25:0]};
        endcase
      end
    endcase
  endfunction

  function automatic void push(int k, int c, logic [63:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.v    = v;
    sbq.push_back(e);
  endfunction

  function automatic void bump(int c);
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
    push(2, c, 64'(model_cnt));
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got === req) passed++;
    else $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
  endtask

  task automatic sb_check(input int k, input logic [63:0] v);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      $display("FAIL sb_unexpected kind=%0d cyc=%0d got=%0h required=none", k, cyc, v);
    end else begin
      e = sbq.pop_front();
      if (e.kind == k && e.cyc == cyc && e.v === v) passed++;
      else $display("FAIL sb_event got kind=%0d cyc=%0d v=%0h required kind=%0d cyc=%0d v=%0h",
                    k, cyc, v, e.kind, e.cyc, e.v);
    end
  endtask

  // Monitor: every cycle with a strobe or a counter change is one scoreboard event.
  initial begin
    logic [CNT_W-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (bus.alu_en | bus.mem_req | bus.reg_we)
        sb_check(1, pk({bus.alu_en, bus.mem_req, bus.reg_we}, bus.alu_op, bus.alu_src,
                       bus.mem_we, bus.wb_sel, bus.rs, bus.rt, bus.wa, bus.imm));
      if (bus.retired !== prev) begin
        sb_check(2, 64'(bus.retired));
        prev = bus.retired;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.inst_valid = 1'b0;
    bus.mem_ack = 1'b0;
    if (model_cnt != 0) push(2, cyc + 1, 64'(0));
    model_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.inst_ready), 64'(0));
      if (i == n - 1 && n >= 2) begin
        chk("rst_outputs", pk({bus.alu_en, bus.mem_req, bus.reg_we}, bus.alu_op, bus.alu_src,
                              bus.mem_we, bus.wb_sel, bus.rs, bus.rt, bus.wa, bus.imm), 64'(0));
        chk("rst_retired_illegal", {bus.illegal, 32'(bus.retired)}, 64'(0));
      end
      tick();
    end
    rst = 1'b0;
    exp_ready = cyc;
  endtask

  // Offer one instruction, follow it to completion and predict every observable event.
  task automatic issue(input logic [31:0] w, input int wt, input int abort_j);
    int          a, t0, kd, L, want;
    bit          acc, is_mem;
    logic [4:0]  rs, rt, wa;
    logic [15:0] imm;
    logic [1:0]  op;
    t0 = cyc;
    bus.inst = w;
    bus.inst_valid = 1'b1;
    acc = 1'b0;
    a = 0;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (bus.inst_ready) begin
        acc = 1'b1;
        a = cyc;
      end
    end
    if (!acc) begin
      checks++;
      $display("FAIL accept_timeout cyc=%0d got=no_ready required=ready_by_%0d", cyc, exp_ready);
      bus.inst_valid = 1'b0;
      return;
    end
    want = (exp_ready > t0) ? exp_ready : t0;
    chk("accept_cycle", 64'(a), 64'(want));
    tick();
    kd  = classify(w);
    rs  = w[25:21];
    rt  = w[20:16];
    imm = w[15:0];
    wa  = (w[31:26] == 6'h00) ? w[15:11] : w[20:16];
    is_mem = (kd == 3) || (kd == 4);
    op = (kd == 1) ? 2'b01 : (kd == 2) ? 2'b10 : 2'b00;
    L = 2;
    if (kd <= 2) begin
      push(1, a + 2, pk(3'b100, op, 1'b0, 1'b0, 1'b0, rs, rt, wa, imm));
      push(1, a + 3, pk(3'b001, 2'b00, 1'b0, 1'b0, 1'b0, rs, rt, wa, imm));
      bump(a + 4);
      L = 4;
    end else if (is_mem) begin
      push(1, a + 2, pk(3'b100, 2'b00, 1'b1, 1'b0, 1'b0, rs, rt, wa, imm));
      if (abort_j >= 0) begin
        for (int i = 0; i <= abort_j; i++)
          push(1, a + 3 + i, pk(3'b010, 2'b00, 1'b0, kd == 4, 1'b0, rs, rt, wa, imm));
        if (model_cnt != 0) push(2, a + 4 + abort_j, 64'(0));
        model_cnt = 0;
        L = 4 + abort_j;
      end else begin
        for (int i = 0; i <= wt; i++)
          push(1, a + 3 + i, pk(3'b010, 2'b00, 1'b0, kd == 4, 1'b0, rs, rt, wa, imm));
        if (kd == 3) begin
          push(1, a + 4 + wt, pk(3'b001, 2'b00, 1'b0, 1'b0, 1'b1, rs, rt, wa, imm));
          bump(a + 5 + wt);
          L = 5 + wt;
        end else begin
          bump(a + 4 + wt);
          L = 4 + wt;
        end
      end
    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
      L = 6;
`else
      bump(a + 2);
      L = 2;
`endif
    end
    for (int k = 1; k < L; k++) begin
      bus.inst_valid = 1'($urandom_range(0, 1));
      bus.inst = $urandom;
      if (is_mem && k >= 3) bus.mem_ack = (abort_j < 0) && (k == 3 + wt);
      else bus.mem_ack = 1'($urandom_range(0, 1));
      if (abort_j >= 0 && k == 3 + abort_j) rst = 1'b1;
      @(negedge clk);
      if (kd == 5) begin
`ifdef MC_ILLEGAL_TRAP_EN
        if (k == 1) begin
          chk("trap_decode_illegal", 64'(bus.illegal), 64'(0));
        end else begin
          chk("trap_illegal", 64'(bus.illegal), 64'(1));
          chk("trap_ready", 64'(bus.inst_ready), 64'(0));
        end
`else
        chk("nop_illegal", 64'(bus.illegal), 64'(0));
`endif
      end
      tick();
    end
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    bus.inst_valid = 1'b0;
    exp_ready = a + L;
`ifdef MC_ILLEGAL_TRAP_EN
    if (kd == 5) do_reset(2);
`endif
  endtask

  initial begin
    int k, wt, ab;
    rst = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst = '0;
    bus.mem_ack = 1'b0;
    tick();
    do_reset(3);

    issue(32'h00221820, 0, -1);
    issue(32'h00221822, 0, -1);
    issue(32'h0022182A, 0, -1);
    issue(32'h8C220004, 3, -1);
    issue(32'hAC220008, 0, -1);
    issue(32'hFC000000, 0, -1);
    issue(32'h8C220004, 4, 1);
    issue(32'h00221820, 0, -1);

    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 5);
      wt = $urandom_range(0, 3);
      ab = -1;
      if ((k == 3 || k == 4) && wt > 0 && $urandom_range(0, 19) == 0) ab = $urandom_range(0, wt - 1);
      if ($urandom_range(0, 2) == 0) begin
        bus.inst = $urandom;
        repeat ($urandom_range(1, 3)) tick();
      end
      issue(rand_inst(k), wt, ab);
    end

    repeat (6) tick();
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
